// File: rtl/td4_core.sv
// TD4-style 4-bit CPU core: two-phase fetch/execute with A, B, OUT, carry and PC.
// The program ROM is external and returns its word combinationally for rom_addr.
module td4_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_qd,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       c_flag,
  output logic       phase
);

  // state | meaning
  // FETCH | latch rom_qd into ir
  // EXEC  | execute ir, update pc, return to FETCH
  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t     state;
  logic [7:0] ir;
  logic [3:0] pc;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] out_r;
  logic       c;

  logic [3:0] opcode;
  logic [3:0] im;
  logic [4:0] sum_a;
  logic [4:0] sum_b;
  logic [3:0] pc_inc;

  assign opcode = ir[7:4];
  assign im     = ir[3:0];
  assign sum_a  = {1'b0, a} + {1'b0, im};
  assign sum_b  = {1'b0, b} + {1'b0, im};
  assign pc_inc = pc + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ir    <= 8'h00;
      pc    <= 4'h0;
      a     <= 4'h0;
      b     <= 4'h0;
      out_r <= 4'h0;
      c     <= 1'b0;
    end else if (en) begin
      case (state)
        FETCH: begin
          ir    <= rom_qd;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          // Carry survives only an ADD; everything else, including jumps, clears it.
          c     <= 1'b0;
          pc    <= pc_inc;
          case (opcode)
            4'b0000: {c, a} <= sum_a;
            4'b0101: {c, b} <= sum_b;
            4'b0011: a <= im;
            4'b0111: b <= im;
            4'b0001: a <= b;
            4'b0100: b <= a;
            4'b0010: a <= in_port;
            4'b0110: b <= in_port;
            4'b1001: out_r <= b;
            4'b1011: out_r <= im;
            4'b1111: pc <= im;
            4'b1110: if (!c) pc <= im;
            default: ;
          endcase
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign rom_addr = pc;
  assign out_port = out_r;
  assign c_flag   = c;
  assign phase    = (state == EXEC);

endmodule

// File: tb/tb_td4_core.sv
// Scoreboard bench for td4_core: directed programs push per-instruction expectations,
// a monitor compares architectural state at each completed EXEC edge.
module tb_td4_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_qd;
  logic [3:0] in_port = 4'h0;
  logic [3:0] out_port;
  logic       c_flag;
  logic       phase;

  logic [7:0] rom [16];

  typedef struct {
    int         id;
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic       c;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_vec = 0;
  int   n_err = 0;

  td4_core dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_qd   (rom_qd),
    .in_port  (in_port),
    .out_port (out_port),
    .c_flag   (c_flag),
    .phase    (phase)
  );

  always #5 clk = ~clk;
  assign rom_qd = rom[rom_addr];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic ex(input int id, input logic [3:0] pc, input logic [3:0] a,
                    input logic [3:0] b, input logic [3:0] o, input logic c);
    exp_t e;
    e.id = id; e.pc = pc; e.a = a; e.b = b; e.o = o; e.c = c;
    sb.push_back(e);
  endtask

  // Monitor: each enabled EXEC edge retires one instruction.
  always @(posedge clk) begin
    if (!rst && en && phase) begin
      #1;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_retire: got pc %h, expected no instruction", rom_addr);
      end else begin
        me = sb.pop_front();
        chk($sformatf("i%0d.pc", me.id), {4'h0, rom_addr}, {4'h0, me.pc});
        chk($sformatf("i%0d.a", me.id), {4'h0, dut.a}, {4'h0, me.a});
        chk($sformatf("i%0d.b", me.id), {4'h0, dut.b}, {4'h0, me.b});
        chk($sformatf("i%0d.out", me.id), {4'h0, out_port}, {4'h0, me.o});
        chk($sformatf("i%0d.c", me.id), {7'h0, c_flag}, {7'h0, me.c});
        chk($sformatf("i%0d.phase", me.id), {7'h0, phase}, 8'h00);
      end
    end
  end

  task automatic step(input int n);
    @(negedge clk);
    en = 1'b1;
    repeat (n) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst.addr", {4'h0, rom_addr}, 8'h00);
    chk("rst.out", {4'h0, out_port}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  initial begin
    // OUT Im, hold, mid-EXEC reset
    fill_nop();
    rom[0] = 8'hB3;
    rom[1] = 8'hB6;
    do_reset();
    chk("a.phase0", {7'h0, phase}, 8'h00);
    ex(10, 4'h1, 4'h0, 4'h0, 4'h3, 1'b0);
    ex(11, 4'h2, 4'h0, 4'h0, 4'h6, 1'b0);
    step(1);
    chk("a.fetched", {7'h0, phase}, 8'h01);
    repeat (10) @(negedge clk);
    chk("a.hold_phase", {7'h0, phase}, 8'h01);
    chk("a.hold_addr", {4'h0, rom_addr}, 8'h00);
    step(3);
    wait_empty("a");
    repeat (10) @(negedge clk);
    chk("a.hold_out", {4'h0, out_port}, 8'h06);
    chk("a.hold_addr2", {4'h0, rom_addr}, 8'h02);
    step(1);
    chk("a.exec_before_rst", {7'h0, phase}, 8'h01);
    rst = 1'b1;
    #1;
    chk("a.rst_out", {4'h0, out_port}, 8'h00);
    chk("a.rst_addr", {4'h0, rom_addr}, 8'h00);
    chk("a.rst_c", {7'h0, c_flag}, 8'h00);
    chk("a.rst_phase", {7'h0, phase}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("a.post_hold_out", {4'h0, out_port}, 8'h00);
    chk("a.post_hold_addr", {4'h0, rom_addr}, 8'h00);
    ex(12, 4'h1, 4'h0, 4'h0, 4'h3, 1'b0);
    step(2);
    wait_empty("a2");

    // Carry then JNC falls through
    fill_nop();
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0; rom[3] = 8'hB5;
    do_reset();
    ex(20, 4'h1, 4'hF, 4'h0, 4'h0, 1'b0);
    ex(21, 4'h2, 4'h0, 4'h0, 4'h0, 1'b1);
    ex(22, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
    ex(23, 4'h4, 4'h0, 4'h0, 4'h5, 1'b0);
    step(8);
    wait_empty("b");

    // JNC taken
    fill_nop();
    rom[0] = 8'h31; rom[1] = 8'h01; rom[2] = 8'hE7;
    do_reset();
    ex(30, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    ex(31, 4'h2, 4'h2, 4'h0, 4'h0, 1'b0);
    ex(32, 4'h7, 4'h2, 4'h0, 4'h0, 1'b0);
    step(6);
    wait_empty("c");

    // IN B / OUT B, NOP padding, PC wrap
    fill_nop();
    rom[0] = 8'h60; rom[1] = 8'h90;
    do_reset();
    in_port = 4'hA;
    ex(40, 4'h1, 4'h0, 4'hA, 4'h0, 1'b0);
    step(2);
    wait_empty("d0");
    in_port = 4'h5;
    ex(41, 4'h2, 4'h0, 4'hA, 4'hA, 1'b0);
    for (int i = 2; i < 16; i++) ex(40 + i, 4'(i + 1), 4'h0, 4'hA, 4'hA, 1'b0);
    step(30);
    wait_empty("d");

    // Undefined opcodes as NOP, carry then JMP
    fill_nop();
    rom[0] = 8'h3F; rom[1] = 8'hA7; rom[2] = 8'hD3; rom[3] = 8'h8F; rom[4] = 8'hC0;
    rom[8] = 8'h01; rom[9] = 8'hF0;
    do_reset();
    for (int i = 0; i < 8; i++) ex(60 + i, 4'(i + 1), 4'hF, 4'h0, 4'h0, 1'b0);
    ex(68, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1);
    ex(69, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(20);
    wait_empty("e");

    // ADD B carry, MOV A,B, MOV B,A, ADD A carry, IN A, OUT B
    fill_nop();
    rom[0] = 8'h75; rom[1] = 8'h5C; rom[2] = 8'h10; rom[3] = 8'h40;
    rom[4] = 8'h0F; rom[5] = 8'h20; rom[6] = 8'h90;
    do_reset();
    in_port = 4'h9;
    ex(70, 4'h1, 4'h0, 4'h5, 4'h0, 1'b0);
    ex(71, 4'h2, 4'h0, 4'h1, 4'h0, 1'b1);
    ex(72, 4'h3, 4'h1, 4'h1, 4'h0, 1'b0);
    ex(73, 4'h4, 4'h1, 4'h1, 4'h0, 1'b0);
    ex(74, 4'h5, 4'h0, 4'h1, 4'h0, 1'b1);
    ex(75, 4'h6, 4'h9, 4'h1, 4'h0, 1'b0);
    ex(76, 4'h7, 4'h9, 4'h1, 4'h1, 1'b0);
    step(14);
    wait_empty("f");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
